crossyroad_lane_engine: RTL

//   Parametrised obstacle/game core for the crossyroad VGA game: NUM_LANES obstacle lanes

---
 rtl/crossyroad_pkg.sv | 34 +++
 rtl/crossyroad_lane.sv | 63 ++++++
 rtl/crossyroad_lane_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/crossyroad_pkg.sv
// Shared geometry, colour codes, game states and lane-speed helper for the crossyroad game core.
package crossyroad_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned COORD_W  = 10;

    localparam int unsigned CHICK_X0 = 310;
    localparam int unsigned CHICK_X1 = 339;
    localparam int unsigned CHICK_Y0 = 400;
    localparam int unsigned CHICK_Y1 = 439;

    localparam logic [2:0] RGB_NONE  = 3'b000;
    localparam logic [2:0] RGB_OBS   = 3'b001;
    localparam logic [2:0] RGB_CHICK = 3'b010;
    localparam logic [2:0] RGB_FLASH = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10
    } game_state_e;

    // 1 + (score >> shift), clamped to max_spd
    function automatic logic [2:0] lane_speed(input logic [6:0] score_v,
                                              input int unsigned shift,
                                              input int unsigned max_spd);
        logic [6:0] base;
        base = score_v >> shift;
        if (base >= 7'(max_spd)) return 3'(max_spd);
        return 3'(base + 7'd1);
    endfunction

endpackage

// File: rtl/crossyroad_lane.sv
// One obstacle lane: position registers, horizontal wrap, vertical ring scroll and pixel hit test.
module crossyroad_lane
    import crossyroad_pkg::*;
#(
    parameter int unsigned IDX        = 0,
    parameter int unsigned LANE_PITCH = 120,
    parameter int unsigned X_OFFSET   = 250,
    parameter int unsigned OBS_W      = 50,
    parameter int unsigned OBS_H      = 30,
    parameter int unsigned MOVE_STEP  = 30,
    parameter int unsigned RING_H     = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_i,
    input  logic                step_i,
    input  logic                scroll_i,
    input  logic [2:0]          spd_i,
    input  logic [COORD_W-1:0]  pixel_x_i,
    input  logic [COORD_W-1:0]  pixel_y_i,
    output logic                in_obs_c_o
);

    localparam logic [COORD_W-1:0] X_INIT = COORD_W'((IDX * X_OFFSET) % H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(IDX * LANE_PITCH);
    localparam bit                 MOVES_LEFT = (IDX % 2) == 1;

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, spd_w;

    // Odd lanes run leftwards, even lanes rightwards; both wrap inside the 640-px line
    always_comb begin
        spd_w = COORD_W'(spd_i);
        x_d   = x_q;
        y_d   = y_q;
        if (step_i) begin
            if (MOVES_LEFT) begin
                x_d = (x_q < spd_w) ? x_q + (COORD_W'(H_ACTIVE) - spd_w) : x_q - spd_w;
            end else begin
                x_d = x_q + spd_w;
                if (x_d >= COORD_W'(H_ACTIVE)) x_d = x_d - COORD_W'(H_ACTIVE);
            end
            if (scroll_i) begin
                y_d = y_q + COORD_W'(MOVE_STEP);
                if (y_d >= COORD_W'(RING_H)) y_d = y_d - COORD_W'(RING_H);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || init_i) begin
            x_q <= X_INIT;
            y_q <= Y_INIT;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign in_obs_c_o = (pixel_x_i >= x_q) && (pixel_x_i < x_q + COORD_W'(OBS_W)) &&
                        (pixel_y_i >= y_q) && (pixel_y_i < y_q + COORD_W'(OBS_H)) &&
                        (pixel_y_i < COORD_W'(V_ACTIVE));

endmodule

// File: rtl/crossyroad_lane_engine.sv
// Crossyroad game core: obstacle lanes, move capture, score, collision and IDLE/PLAY/HIT FSM.
module crossyroad_lane_engine
    import crossyroad_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned LANE_PITCH  = 120,
    parameter int unsigned X_OFFSET    = 250,
    parameter int unsigned OBS_W       = 50,
    parameter int unsigned OBS_H       = 30,
    parameter int unsigned MOVE_STEP   = 30,
    parameter int unsigned SPEED_SHIFT = 3,
    parameter int unsigned MAX_SPEED   = 7,
    parameter int unsigned HIT_FRAMES  = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                move_btn,
    input  logic [COORD_W-1:0]  pixel_x,
    input  logic [COORD_W-1:0]  pixel_y,
    input  logic                video_on,
    output logic [2:0]          obj_rgb,
    output logic                obj_valid,
    output logic [6:0]          score,
    output logic [1:0]          game_state
);

    localparam int unsigned RING_H     = NUM_LANES * LANE_PITCH;
    localparam int unsigned HIT_CNT_W  = ($clog2(HIT_FRAMES) > 4) ? $clog2(HIT_FRAMES) : 4;
    localparam logic [6:0]  SCORE_MAX  = 7'd99;

    game_state_e            state_q;
    logic [6:0]             score_q;
    logic [HIT_CNT_W-1:0]   hit_cnt_q;
    logic                   btn_q, move_pend_q, hit_flag_q, chick_q, obs_q;
    logic [2:0]             obj_rgb_q;
    logic                   obj_valid_q;

    logic                   btn_edge_c, lane_init_c, lane_step_c, lane_scroll_c;
    logic                   chick_c, obs_any_c;
    logic [2:0]             spd_c;
    logic [NUM_LANES-1:0]   lane_hit_c;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        crossyroad_lane #(
            .IDX        (i),
            .LANE_PITCH (LANE_PITCH),
            .X_OFFSET   (X_OFFSET),
            .OBS_W      (OBS_W),
            .OBS_H      (OBS_H),
            .MOVE_STEP  (MOVE_STEP),
            .RING_H     (RING_H)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .init_i     (lane_init_c),
            .step_i     (lane_step_c),
            .scroll_i   (lane_scroll_c),
            .spd_i      (spd_c),
            .pixel_x_i  (pixel_x),
            .pixel_y_i  (pixel_y),
            .in_obs_c_o (lane_hit_c[i])
        );
    end

    // Lane control decoded from the current state; all of it acts only on frame_tick
    always_comb begin
        btn_edge_c    = move_btn & ~btn_q;
        spd_c         = lane_speed(score_q, SPEED_SHIFT, MAX_SPEED);
        lane_step_c   = frame_tick && (state_q == ST_PLAY) && !hit_flag_q;
        lane_scroll_c = lane_step_c && move_pend_q;
        lane_init_c   = frame_tick && (state_q == ST_HIT) &&
                        (hit_cnt_q == HIT_CNT_W'(HIT_FRAMES - 1));
        obs_any_c     = |lane_hit_c;
        chick_c       = (pixel_x >= COORD_W'(CHICK_X0)) && (pixel_x <= COORD_W'(CHICK_X1)) &&
                        (pixel_y >= COORD_W'(CHICK_Y0)) && (pixel_y <= COORD_W'(CHICK_Y1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            hit_cnt_q   <= '0;
            btn_q       <= 1'b0;
            move_pend_q <= 1'b0;
            hit_flag_q  <= 1'b0;
            chick_q     <= 1'b0;
            obs_q       <= 1'b0;
            obj_rgb_q   <= RGB_NONE;
            obj_valid_q <= 1'b0;
        end else begin
            btn_q       <= move_btn;
            // An edge coinciding with frame_tick belongs to the next frame
            move_pend_q <= frame_tick ? btn_edge_c : (move_pend_q | btn_edge_c);

            chick_q     <= video_on & chick_c;
            obs_q       <= video_on & obs_any_c;
            obj_valid_q <= video_on & (chick_c | obs_any_c);
            if (!video_on)      obj_rgb_q <= RGB_NONE;
            else if (chick_c)   obj_rgb_q <= (state_q == ST_HIT && hit_cnt_q[3]) ? RGB_FLASH : RGB_CHICK;
            else if (obs_any_c) obj_rgb_q <= RGB_OBS;
            else                obj_rgb_q <= RGB_NONE;

            if (frame_tick)                                     hit_flag_q <= 1'b0;
            else if (state_q == ST_PLAY && chick_q && obs_q)    hit_flag_q <= 1'b1;

            if (frame_tick) begin
                case (state_q)
                    ST_IDLE: if (move_pend_q) state_q <= ST_PLAY;
                    ST_PLAY: begin
                        if (hit_flag_q) begin
                            state_q   <= ST_HIT;
                            hit_cnt_q <= '0;
                        end else if (move_pend_q && score_q != SCORE_MAX) begin
                            score_q <= score_q + 7'd1;
                        end
                    end
                    ST_HIT: begin
                        if (lane_init_c) begin
                            state_q   <= ST_IDLE;
                            score_q   <= '0;
                            hit_cnt_q <= '0;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + HIT_CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign obj_rgb    = obj_rgb_q;
    assign obj_valid  = obj_valid_q;
    assign score      = score_q;
    assign game_state = state_q;

endmodule
